// File: rtl/pipe_shifter.sv
// Multi-cycle shifter: one bit position per clock, result registered on completion.
// Supports logical right/left, arithmetic right and rotate right.
module pipe_shifter #(
   parameter int DATAWIDTH = 8
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 start,
   input  logic [1:0]           mode,
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] sh_amt,
   output logic [DATAWIDTH-1:0] d,
   output logic                 busy,
   output logic                 done
);

   localparam int CW = $clog2(DATAWIDTH + 1);
   localparam logic [DATAWIDTH-1:0] DW_V = DATAWIDTH'(DATAWIDTH);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t               state;
   logic [DATAWIDTH-1:0] work;
   logic [CW-1:0]        cnt;
   logic [1:0]           mode_q;

   logic [DATAWIDTH-1:0] n_full;
   logic [CW-1:0]        n_eff;
   logic [DATAWIDTH-1:0] step;

   // Rotation wraps modulo width; the other modes saturate at full width.
   always_comb begin
      n_full = sh_amt;
      if (mode == 2'b11) begin
         n_full = sh_amt % DW_V;
      end else if (sh_amt >= DW_V) begin
         n_full = DW_V;
      end
      n_eff = CW'(n_full);
   end

   always_comb begin
      step = work;
      case (mode_q)
         2'b00:   step = {1'b0, work[DATAWIDTH-1:1]};
         2'b01:   step = {work[DATAWIDTH-2:0], 1'b0};
         2'b10:   step = {work[DATAWIDTH-1], work[DATAWIDTH-1:1]};
         default: step = {work[0], work[DATAWIDTH-1:1]};
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state  <= IDLE;
         work   <= '0;
         cnt    <= '0;
         mode_q <= 2'b00;
         d      <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  work   <= a;
                  mode_q <= mode;
                  cnt    <= n_eff;
                  if (n_eff == '0) begin
                     state <= DONE;
                     d     <= a;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     state <= BUSY;
                     busy  <= 1'b1;
                  end
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            BUSY: begin
               work <= step;
               cnt  <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state <= DONE;
                  d     <= step;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  busy <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_shifter.sv
// Randomised and directed bench for pipe_shifter against an arithmetic reference.
module tb_pipe_shifter;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic       start = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [7:0] a = 8'h00;
   logic [7:0] sh_amt = 8'h00;
   logic [7:0] d;
   logic       busy;
   logic       done;

   int tests = 0;
   int fails = 0;
   logic [7:0] exp_d = 8'h00;
   logic [1:0] nx_mode;
   logic [7:0] nx_a;
   logic [7:0] nx_sh;

   pipe_shifter #(.DATAWIDTH(8)) dut (
      .Clk(Clk), .Rst(Rst), .start(start), .mode(mode),
      .a(a), .sh_amt(sh_amt), .d(d), .busy(busy), .done(done)
   );

   always #5 Clk = ~Clk;

   function automatic int ref_n(input logic [1:0] m, input logic [7:0] s);
      if (m == 2'b11) return int'(s) % 8;
      return (s > 8) ? 8 : int'(s);
   endfunction

   function automatic logic [7:0] ref_res(input logic [1:0] m,
                                          input logic [7:0] av,
                                          input logic [7:0] s);
      int n;
      logic [15:0] t;
      logic signed [7:0] sa;
      n = ref_n(m, s);
      case (m)
         2'b00: t = {8'h00, av} >> n;
         2'b01: t = {8'h00, av} << n;
         2'b10: begin
            sa = av;
            t = {8'h00, 8'(sa >>> n)};
         end
         default: t = {av, av} >> n;
      endcase
      return t[7:0];
   endfunction

   task automatic run_op(input logic [1:0] m, input logic [7:0] av,
                         input logic [7:0] sv, input bit poke,
                         input bit pre, input bit chain, input string name);
      int n;
      logic [7:0] r;
      n = ref_n(m, sv);
      r = ref_res(m, av, sv);
      if (!pre) begin
         start = 1'b1; mode = m; a = av; sh_amt = sv;
      end
      @(posedge Clk); #1;
      for (int i = 0; i <= n; i++) begin
         tests++;
         if (busy !== (i < n) || done !== (i == n)) begin
            fails++;
            $display("FAIL %s cyc%0d busy/done=%b%b expected %b%b",
                     name, i, busy, done, (i < n), (i == n));
         end
         tests++;
         if (i < n && d !== exp_d) begin
            fails++;
            $display("FAIL %s hold cyc%0d d=%h expected %h", name, i, d, exp_d);
         end else if (i == n && d !== r) begin
            fails++;
            $display("FAIL %s result m=%0d a=%h sh=%0d d=%h expected %h",
                     name, m, av, sv, d, r);
         end
         start = 1'b0;
         if (i == 0 && poke && n > 0) begin
            start = 1'b1; mode = 2'($urandom_range(0, 3));
            a = 8'h01; sh_amt = 8'($urandom_range(0, 7));
         end
         if (i == n) begin
            exp_d = r;
            if (chain) begin
               start = 1'b1; mode = nx_mode; a = nx_a; sh_amt = nx_sh;
            end
         end else begin
            @(posedge Clk); #1;
         end
      end
      if (!chain) begin
         @(posedge Clk); #1;
         tests++;
         if (busy !== 1'b0 || done !== 1'b0 || d !== exp_d) begin
            fails++;
            $display("FAIL %s idle busy/done=%b%b d=%h expected 00 %h",
                     name, busy, done, d, exp_d);
         end
      end
   endtask

   task automatic test_reset();
      Rst = 1'b1; start = 1'b1; mode = 2'b01; a = 8'hFF; sh_amt = 8'h03;
      repeat (2) @(posedge Clk);
      #1;
      tests++;
      if (d !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL reset d=%h busy=%b done=%b expected 00 0 0", d, busy, done);
      end
      exp_d = 8'h00;
      Rst = 1'b0;
      run_op(2'b00, 8'hB4, 8'd3, 1'b0, 1'b0, 1'b0, "first_after_reset");
   endtask

   task automatic test_vectors();
      run_op(2'b10, 8'hB4, 8'd2,   1'b0, 1'b0, 1'b0, "asr2");
      run_op(2'b10, 8'h80, 8'd255, 1'b0, 1'b0, 1'b0, "asr_sat");
      run_op(2'b01, 8'h81, 8'd1,   1'b0, 1'b0, 1'b0, "lsl1");
      run_op(2'b11, 8'h81, 8'd9,   1'b0, 1'b0, 1'b0, "ror9");
      run_op(2'b11, 8'h5A, 8'd16,  1'b0, 1'b0, 1'b0, "ror16");
      run_op(2'b00, 8'h3C, 8'd0,   1'b0, 1'b0, 1'b0, "zero_shift");
      run_op(2'b01, 8'hFF, 8'd8,   1'b0, 1'b0, 1'b0, "lsl8");
   endtask

   task automatic test_ignore_busy();
      run_op(2'b00, 8'hFF, 8'd200, 1'b1, 1'b0, 1'b0, "busy_start_sat");
      run_op(2'b00, 8'hB4, 8'd3,   1'b1, 1'b0, 1'b0, "busy_start_lsr3");
      run_op(2'b11, 8'hB4, 8'd1,   1'b1, 1'b0, 1'b0, "busy_start_ror1");
   endtask

   task automatic test_back_to_back();
      nx_mode = 2'b10; nx_a = 8'h96; nx_sh = 8'd2;
      run_op(2'b01, 8'h35, 8'd3, 1'b0, 1'b0, 1'b1, "b2b_first");
      run_op(nx_mode, nx_a, nx_sh, 1'b0, 1'b1, 1'b0, "b2b_second");
      nx_mode = 2'b11; nx_a = 8'hC3; nx_sh = 8'd8;
      run_op(2'b00, 8'hF0, 8'd1, 1'b0, 1'b0, 1'b1, "b2b_zero_first");
      run_op(nx_mode, nx_a, nx_sh, 1'b0, 1'b1, 1'b0, "b2b_zero_second");
   endtask

   task automatic test_abort();
      run_op(2'b00, 8'hB4, 8'd3, 1'b0, 1'b0, 1'b0, "pre_abort");
      start = 1'b1; mode = 2'b00; a = 8'hE7; sh_amt = 8'd5;
      @(posedge Clk); #1;
      start = 1'b0;
      @(posedge Clk); #1;
      Rst = 1'b1;
      @(posedge Clk); #1;
      tests++;
      if (d !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL abort d=%h busy=%b done=%b expected 00 0 0", d, busy, done);
      end
      exp_d = 8'h00;
      Rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge Clk); #1;
         tests++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_quiet cyc%0d busy/done=%b%b expected 00",
                     i, busy, done);
         end
      end
      run_op(2'b10, 8'h92, 8'd5, 1'b0, 1'b0, 1'b0, "post_abort");
   endtask

   task automatic test_random();
      logic [1:0] m;
      logic [7:0] av;
      logic [7:0] sv;
      bit pk;
      bit ch;
      for (int i = 0; i < 60; i++) begin
         m  = 2'($urandom_range(0, 3));
         av = 8'($urandom);
         sv = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
         pk = 1'($urandom_range(0, 1));
         ch = 1'($urandom_range(0, 1));
         if (ch) begin
            nx_mode = 2'($urandom_range(0, 3));
            nx_a = 8'($urandom);
            nx_sh = 8'($urandom_range(0, 12));
            run_op(m, av, sv, pk, 1'b0, 1'b1, "random_chain");
            run_op(nx_mode, nx_a, nx_sh, 1'b0, 1'b1, 1'b0, "random_chain2");
         end else begin
            run_op(m, av, sv, pk, 1'b0, 1'b0, "random");
         end
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_ignore_busy();
      test_back_to_back();
      test_abort();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
